decoder_onehot_scan: RTL
========================

Name: decoder_onehot_scan

Overview:
Parametrised, registered successor to the team's 3-to-8 decoder. It converts a SEL_W-bit binary code into a 2^SEL_W one-hot output. It also has an auto-scan mode that steps the active bit through all outputs at a programmable dwell rate, for running-light and channel-select use.
All outputs are flops. The output holds its value explicitly between updates, so no latches are inferred.

Parameters:
SEL_W, 3, width of the binary code; the output is 2^SEL_W bits wide.
DWELL_W, 16, width of the dwell counter and the dwell input.
RST_CODE, 0, index whose bit is active after reset; must be < 2^SEL_W.

Ports:
sys_clk  input  1  system clock; all logic on the rising edge.
sys_rst  input  1  synchronous reset, active-high.
en  input  1  global enable; when low, all state holds.
mode  input  1  0 = DIRECT, 1 = SCAN.
scan_dir  input  1  SCAN step direction: 0 = up (index +1), 1 = down (index -1).
in_valid  input  1  load strobe for in_code.
in_code  input  SEL_W  binary index to decode or load.
dwell  input  DWELL_W  SCAN mode: number of extra cycles the index is held before each step.
out  output  2^SEL_W  registered one-hot output.
out_idx  output  SEL_W  binary index of the active bit in out.
out_upd  output  1  one-cycle pulse in the cycle after out/out_idx is written.

Behaviour:
- Reset (sys_rst=1 at a clock edge): out = 1<<RST_CODE, out_idx = RST_CODE, out_upd = 0, dwell counter cnt = 0.
- Reset has priority over every other input, including mid-scan and mid-load.
- Invariants:
  - out always equals 1<<out_idx.
  - Exactly one bit of out is set, every cycle.
- en = 0: out, out_idx and cnt hold; out_upd = 0; in_valid is ignored and dropped.
- DIRECT mode (mode=0, en=1):
  - in_valid=1 → next edge: out_idx = in_code, out = 1<<in_code, out_upd = 1. Latency is 1 clock.
  - A load of the current index still pulses out_upd.
  - in_valid=0 → out holds, out_upd = 0.
  - cnt is forced to 0.
- SCAN mode (mode=1, en=1):
  - cnt increments each cycle.
  - When cnt >= dwell (live compare against the current dwell input): cnt → 0, out_idx steps by ±1 modulo 2^SEL_W, out_upd = 1.
  - Each index is therefore held dwell+1 cycles.
  - dwell = 0 → the index steps every cycle and out_upd stays high continuously.
  - Wrap-around: up from 2^SEL_W-1 goes to 0; down from 0 goes to 2^SEL_W-1.
  - in_valid=1 in SCAN: out_idx = in_code, cnt = 0, out_upd = 1. This beats a coincident step.
  - dwell lowered below the current cnt: the step occurs at the next edge (>= compare). No wrap through 2^DWELL_W.
  - scan_dir change takes effect on the next step; cnt is not disturbed.
- Mode transitions:
  - SCAN→DIRECT: out holds its current value, cnt is cleared.
  - DIRECT→SCAN: cnt starts at 0; the first step happens dwell+1 cycles after the first SCAN cycle.
- Widths: index arithmetic wraps naturally at SEL_W bits. cnt saturation is not needed because of the >= compare.

Test Plan:
1. Reset / DIRECT sweep: SEL_W=3, RST_CODE=0. Assert sys_rst, then mode=0 and in_valid with codes 0..7 on consecutive cycles → one cycle later out = 0x01, 0x02 … 0x80, out_idx tracks the code, out_upd high each cycle; after reset out=0x01.
2. Hold / enable: load code 5 (out=0x20), then 10 cycles with in_valid=0, then in_valid=1, code=2 with en=0 → out stays 0x20 and out_upd=0 throughout.
3. SCAN up with wrap: from idx 6, mode=1, dwell=2, scan_dir=0 → out_idx sequence 6,6,6,7,7,7,0,0,0,1…; out_upd pulses every 3rd cycle; 0x80 → 0x01 on wrap.
4. SCAN down, dwell=0: from idx 1, scan_dir=1 → out_idx 0,7,6,5 on successive cycles; out_upd constantly high.
5. Load during SCAN coinciding with a step: dwell=3, in_valid=1, code=4 on the step cycle → out_idx=4 (not the stepped index), cnt restarts, next step 4 cycles later to 5.
6. Reset mid-scan and live dwell change: with dwell=9 and cnt=7, set dwell=3 → step at the next edge; then assert sys_rst during SCAN → next edge out=0x01, out_upd=0, cnt=0.

Source files
------------

// File: rtl/decoder_onehot_scan.sv
// ---------------------------------------------------------------------------
// decoder_onehot_scan
//
// Registered binary-to-one-hot decoder with an auto-scan mode. In DIRECT mode
// a strobed code is decoded onto a one-hot output. In SCAN mode the active bit
// walks through the outputs. Each index is held for dwell+1 cycles.
//
// Parameters:
//   SEL_W     width of the binary code; out is 2**SEL_W bits wide
//   DWELL_W   width of the dwell input and the internal dwell counter
//   RST_CODE  index whose bit is active after reset (must be < 2**SEL_W)
//
// Ports:
//   sys_clk   system clock, rising edge
//   sys_rst   synchronous reset, active-high, highest priority
//   en        global enable; when low all state holds and out_upd is 0
//   mode      0 = DIRECT (decode in_code), 1 = SCAN (auto-step)
//   scan_dir  SCAN direction: 0 = index +1, 1 = index -1
//   in_valid  load strobe for in_code (honoured in both modes)
//   in_code   binary index to decode or load
//   dwell     SCAN mode: extra cycles each index is held before stepping
//   out       registered one-hot output, always 1 << out_idx
//   out_idx   binary index of the active bit in out
//   out_upd   high for one cycle after out/out_idx has been written
// ---------------------------------------------------------------------------
module decoder_onehot_scan #(
    parameter int SEL_W    = 3,
    parameter int DWELL_W  = 16,
    parameter int RST_CODE = 0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    scan_dir,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        in_code,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(2**SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    out_upd
);

    localparam int                 OUT_W   = 2**SEL_W;
    localparam logic [SEL_W-1:0]   RST_IDX = SEL_W'(RST_CODE);

    logic [DWELL_W-1:0] cnt;
    logic [SEL_W-1:0]   step_idx;

    // Neighbouring index for the next scan step. The SEL_W-bit arithmetic
    // wraps naturally, so 2**SEL_W-1 + 1 gives 0 and 0 - 1 gives 2**SEL_W-1.
    always_comb begin
        step_idx = scan_dir ? (out_idx - SEL_W'(1)) : (out_idx + SEL_W'(1));
    end

    // Single state register. out and out_idx are always written together, so
    // the one-hot invariant holds on every cycle. A load strobe outranks a
    // scan step. The >= compare against the live dwell value makes a lowered
    // dwell step on the next edge, so the counter never has to wrap.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_idx <= RST_IDX;
            out     <= OUT_W'(1) << RST_IDX;
            out_upd <= 1'b0;
            cnt     <= '0;
        end else if (!en) begin
            out_upd <= 1'b0;
        end else if (!mode) begin
            cnt <= '0;
            if (in_valid) begin
                out_idx <= in_code;
                out     <= OUT_W'(1) << in_code;
                out_upd <= 1'b1;
            end else begin
                out_upd <= 1'b0;
            end
        end else begin
            if (in_valid) begin
                out_idx <= in_code;
                out     <= OUT_W'(1) << in_code;
                out_upd <= 1'b1;
                cnt     <= '0;
            end else if (cnt >= dwell) begin
                out_idx <= step_idx;
                out     <= OUT_W'(1) << step_idx;
                out_upd <= 1'b1;
                cnt     <= '0;
            end else begin
                out_upd <= 1'b0;
                cnt     <= cnt + DWELL_W'(1);
            end
        end
    end

endmodule
